// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  // Rounded clocks-per-oversample-tick divisor.
  function automatic int calc_div(input int clk_hz, input int baud, input int oversample);
    int ticks_hz;
    ticks_hz = baud * oversample;
    return (clk_hz + ticks_hz / 2) / ticks_hz;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Clearable modulo-DIV counter producing a one-cycle oversample tick.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick_o = !clr_i && (cnt_q == CNT_LAST);
    if (clr_i || tick_o) cnt_d = '0;
    else                 cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchroniser, oversampling FSM and avail/ack byte holder.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  input  logic                 ack,
  output logic [DATA_BITS-1:0] data,
  output logic                 avail,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int OSW = $clog2(OVERSAMPLE);
  localparam logic [OSW-1:0] OS_HALF_LAST = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST      = OSW'(OVERSAMPLE - 1);
  localparam logic [2:0]     IDX_LAST     = 3'(DATA_BITS - 1);

  logic [1:0]           sync_q;
  logic                 rxs;
  logic                 tick;
  logic [2:0]           state_q, state_d;
  logic [OSW-1:0]       os_q, os_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 avail_q, avail_d;
  logic                 ovr_q, ovr_d;
  logic                 fe_q, fe_d;
  logic                 good_stop;

  assign rxs = sync_q[1];

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q == ST_IDLE),
    .tick_o(tick)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    os_d      = os_q;
    idx_d     = idx_q;
    shreg_d   = shreg_q;
    fe_d      = 1'b0;
    good_stop = 1'b0;

    case (state_q)
      ST_IDLE: begin
        os_d = '0;
        if (!rxs) state_d = ST_START;
      end
      ST_START: if (tick) begin
        if (os_q == OS_HALF_LAST) begin
          os_d = '0;
          if (rxs) state_d = ST_IDLE;
          else begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
        end else os_d = os_q + 1'b1;
      end
      ST_DATA: if (tick) begin
        if (os_q == OS_LAST) begin
          os_d    = '0;
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) state_d = ST_STOP;
          else                   idx_d   = idx_q + 1'b1;
        end else os_d = os_q + 1'b1;
      end
      ST_STOP: if (tick) begin
        if (os_q == OS_LAST) begin
          os_d = '0;
          if (rxs) begin
            good_stop = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = ST_BREAK;
          end
        end else os_d = os_q + 1'b1;
      end
      ST_BREAK: if (rxs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A good stop outranks a simultaneous ack: the fresh byte stays available.
  always_comb begin
    data_d  = data_q;
    avail_d = avail_q;
    ovr_d   = ovr_q;
    if (good_stop) begin
      data_d  = shreg_q;
      avail_d = 1'b1;
      ovr_d   = (avail_q | ovr_q) & ~ack;
    end else if (ack && avail_q) begin
      avail_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= ST_IDLE;
      os_q    <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      avail_q <= 1'b0;
      ovr_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd};
      state_q <= state_d;
      os_q    <= os_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      avail_q <= avail_d;
      ovr_q   <= ovr_d;
      fe_q    <= fe_d;
    end
  end

  assign data      = data_q;
  assign avail     = avail_q;
  assign overrun   = ovr_q;
  assign frame_err = fe_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
